// File: rtl/sinegen_sweep_ctrl.sv
// sinegen_sweep_ctrl
//   Frequency-sweep scheduler driving the en/incr/step control inputs of the
//   sine generator. A start pulse latches the sweep configuration and steps
//   incr from f_start toward f_stop by f_delta. Each value is held for
//   max(dwell,1) cycles. The sweep either ends (one-shot) or repeats
//   (continuous). All outputs are registered.
//
//   Optional build macro: SWEEP_PINGPONG_EN
//     When defined, continuous mode bounces between f_start and f_stop.
//     When undefined, continuous mode restarts at f_start (sawtooth).
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start, stop     begin sweep (honoured in IDLE), abort (any non-IDLE state)
//   mode            0 = one-shot, 1 = continuous (latched on start)
//   f_start/f_stop  first value / inclusive upper bound (latched on start)
//   f_delta         increment per dwell period (latched on start)
//   dwell           cycles per value, 0 treated as 1 (latched on start)
//   phase_step      phase offset for the second output (latched on start)
//   en, incr, step  sine generator controls
//   busy, done      status: non-IDLE, and a 1-cycle completion pulse
module sinegen_sweep_ctrl #(
  parameter int WIDTH   = 8,
  parameter int DWELL_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic               mode,
  input  logic [WIDTH-1:0]   f_start,
  input  logic [WIDTH-1:0]   f_stop,
  input  logic [WIDTH-1:0]   f_delta,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [WIDTH-1:0]   phase_step,
  output logic               en,
  output logic [WIDTH-1:0]   incr,
  output logic [WIDTH-1:0]   step,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

  state_t             state, state_nx;
  logic               mode_r, mode_nx;
  logic [WIDTH-1:0]   fs_r, fs_nx, fe_r, fe_nx, fd_r, fd_nx;
  logic [DWELL_W-1:0] rl_r, rl_nx;   // dwell reload value, max(dwell,1)-1
  logic [DWELL_W-1:0] cnt, cnt_nx;
  logic               en_nx, busy_nx, done_nx;
  logic [WIDTH-1:0]   incr_nx, step_nx;
  logic [WIDTH:0]     up, dn;        // extra bit holds carry / borrow

`ifdef SWEEP_PINGPONG_EN
  logic dir, dir_nx;                 // 0 = up, 1 = down
`endif

  assign up = {1'b0, incr} + {1'b0, fd_r};
  assign dn = {1'b0, incr} - {1'b0, fd_r};

  always_comb begin
    state_nx = state;
    mode_nx  = mode_r;
    fs_nx    = fs_r;
    fe_nx    = fe_r;
    fd_nx    = fd_r;
    rl_nx    = rl_r;
    cnt_nx   = cnt;
    en_nx    = en;
    incr_nx  = incr;
    step_nx  = step;
    busy_nx  = busy;
    done_nx  = 1'b0;
`ifdef SWEEP_PINGPONG_EN
    dir_nx   = dir;
`endif
    case (state)
      IDLE: begin
        en_nx   = 1'b0;
        busy_nx = 1'b0;
        if (start && !stop) begin
          state_nx = SWEEP;
          mode_nx  = mode;
          fs_nx    = f_start;
          fe_nx    = f_stop;
          fd_nx    = f_delta;
          rl_nx    = (dwell == '0) ? '0 : dwell - DWELL_W'(1);
          cnt_nx   = (dwell == '0) ? '0 : dwell - DWELL_W'(1);
          en_nx    = 1'b1;
          incr_nx  = f_start;
          step_nx  = phase_step;
          busy_nx  = 1'b1;
`ifdef SWEEP_PINGPONG_EN
          dir_nx   = 1'b0;
`endif
        end
      end
      SWEEP: begin
        if (stop) begin
          state_nx = IDLE;
          en_nx    = 1'b0;
          busy_nx  = 1'b0;
        end else if (cnt != '0) begin
          cnt_nx = cnt - DWELL_W'(1);
        end else begin
          cnt_nx = rl_r;
`ifdef SWEEP_PINGPONG_EN
          if (mode_r && dir) begin
            // Falling below f_start turns around; the rebound is clamped.
            if (dn[WIDTH] || (dn[WIDTH-1:0] < fs_r)) begin
              dir_nx  = 1'b0;
              incr_nx = (up > {1'b0, fe_r}) ? fe_r : up[WIDTH-1:0];
            end else begin
              incr_nx = dn[WIDTH-1:0];
            end
          end else
`endif
          if (up <= {1'b0, fe_r}) begin
            incr_nx = up[WIDTH-1:0];
          end else if (!mode_r) begin
            // incr keeps its last value through DONE
            state_nx = DONE;
            en_nx    = 1'b0;
            done_nx  = 1'b1;
          end else begin
`ifdef SWEEP_PINGPONG_EN
            dir_nx  = 1'b1;
            incr_nx = (dn[WIDTH] || (dn[WIDTH-1:0] < fs_r)) ? fs_r : dn[WIDTH-1:0];
`else
            incr_nx = fs_r;
`endif
          end
        end
      end
      DONE: begin
        // stop here also lands in IDLE with done low: same outcome
        state_nx = IDLE;
        en_nx    = 1'b0;
        busy_nx  = 1'b0;
      end
      default: begin
        state_nx = IDLE;
        en_nx    = 1'b0;
        busy_nx  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      mode_r <= 1'b0;
      fs_r   <= '0;
      fe_r   <= '0;
      fd_r   <= '0;
      rl_r   <= '0;
      cnt    <= '0;
      en     <= 1'b0;
      incr   <= '0;
      step   <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
`ifdef SWEEP_PINGPONG_EN
      dir    <= 1'b0;
`endif
    end else begin
      state  <= state_nx;
      mode_r <= mode_nx;
      fs_r   <= fs_nx;
      fe_r   <= fe_nx;
      fd_r   <= fd_nx;
      rl_r   <= rl_nx;
      cnt    <= cnt_nx;
      en     <= en_nx;
      incr   <= incr_nx;
      step   <= step_nx;
      busy   <= busy_nx;
      done   <= done_nx;
`ifdef SWEEP_PINGPONG_EN
      dir    <= dir_nx;
`endif
    end
  end

endmodule

// File: tb/tb_sinegen_sweep_ctrl.sv
// Self-checking bench for sinegen_sweep_ctrl: table of per-cycle vectors with
// hand-computed expected outputs, plus hand-written reset sequences.
module tb_sinegen_sweep_ctrl;

  logic        clk = 1'b0;
  logic        rst, start, stop, mode;
  logic [7:0]  f_start, f_stop, f_delta, phase_step;
  logic [15:0] dwell;
  logic        en, busy, done;
  logic [7:0]  incr, step;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sinegen_sweep_ctrl #(.WIDTH(8), .DWELL_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .mode(mode),
    .f_start(f_start), .f_stop(f_stop), .f_delta(f_delta), .dwell(dwell),
    .phase_step(phase_step), .en(en), .incr(incr), .step(step),
    .busy(busy), .done(done)
  );

  typedef struct {
    logic       start, stop, mode;
    logic [7:0] fs, fe, fd;
    logic [15:0] dw;
    logic [7:0] ps;
    logic       x_en;
    logic [7:0] x_incr, x_step;
    logic       x_busy, x_done;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic st, input logic sp, input logic md,
                     input logic [7:0] fs, input logic [7:0] fe, input logic [7:0] fd,
                     input logic [15:0] dw, input logic [7:0] ps,
                     input logic xe, input logic [7:0] xi, input logic [7:0] xs,
                     input logic xb, input logic xd);
    vec_t v;
    v.start = st; v.stop = sp; v.mode = md; v.fs = fs; v.fe = fe; v.fd = fd;
    v.dw = dw; v.ps = ps; v.x_en = xe; v.x_incr = xi; v.x_step = xs;
    v.x_busy = xb; v.x_done = xd;
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s vec=%0d got=%0d expected=%0d", name, idx, got, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int idx, input logic xe,
                         input logic [7:0] xi, input logic [7:0] xs,
                         input logic xb, input logic xd);
    chk({tag, ".en"},   idx, int'(en),   int'(xe));
    chk({tag, ".incr"}, idx, int'(incr), int'(xi));
    chk({tag, ".step"}, idx, int'(step), int'(xs));
    chk({tag, ".busy"}, idx, int'(busy), int'(xb));
    chk({tag, ".done"}, idx, int'(done), int'(xd));
  endtask

  task automatic drive(input logic st, input logic sp, input logic md,
                       input logic [7:0] fs, input logic [7:0] fe, input logic [7:0] fd,
                       input logic [15:0] dw, input logic [7:0] ps);
    start = st; stop = sp; mode = md; f_start = fs; f_stop = fe;
    f_delta = fd; dwell = dw; phase_step = ps;
  endtask

  initial begin
    // reset with random inputs
    rst = 1'b1;
    drive(1'($urandom), 1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom),
          8'($urandom), 16'($urandom), 8'($urandom));
    @(posedge clk); #1;
    drive(1'($urandom), 1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom),
          8'($urandom), 16'($urandom), 8'($urandom));
    @(posedge clk); #1;
    chk_all("reset", 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    chk_all("idle", 0, 0, 0, 0, 0, 0);

    // one-shot 4..10 step 3 dwell 2
    add(1,0,0, 4,10,3, 2,64,  1, 4,64,1,0);
    add(0,0,0, 4,10,3, 2,64,  1, 4,64,1,0);
    add(0,0,0, 4,10,3, 2,64,  1, 7,64,1,0);
    add(0,0,0, 4,10,3, 2,64,  1, 7,64,1,0);
    add(0,0,0, 4,10,3, 2,64,  1,10,64,1,0);
    add(0,0,0, 4,10,3, 2,64,  1,10,64,1,0);
    add(0,0,0, 4,10,3, 2,64,  0,10,64,1,1);
    add(0,0,0, 4,10,3, 2,64,  0,10,64,0,0);
    // carry out with dwell 0
    add(1,0,0, 250,255,4, 0,5,  1,250,5,1,0);
    add(0,0,0, 250,255,4, 0,5,  1,254,5,1,0);
    add(0,0,0, 250,255,4, 0,5,  0,254,5,1,1);
    add(0,0,0, 250,255,4, 0,5,  0,254,5,0,0);
    // start and stop together in IDLE
    add(1,1,1, 1,3,1, 1,7,  0,254,5,0,0);
    // sawtooth, start mid-sweep ignored, stop without done
    add(1,0,1, 1,3,1, 1,7,  1,1,7,1,0);
    add(0,0,1, 1,3,1, 1,7,  1,2,7,1,0);
    add(1,0,0, 9,20,5, 3,99, 1,3,7,1,0);
    add(0,0,0, 9,20,5, 3,99, 1,1,7,1,0);
    add(0,0,0, 9,20,5, 3,99, 1,2,7,1,0);
    add(0,0,0, 9,20,5, 3,99, 1,3,7,1,0);
    add(0,0,0, 9,20,5, 3,99, 1,1,7,1,0);
    add(0,1,0, 9,20,5, 3,99, 0,1,7,0,0);
    add(0,0,0, 9,20,5, 3,99, 0,1,7,0,0);
    // f_delta = 0 holds f_start until stop
    add(1,0,0, 5,9,0, 1,3,  1,5,3,1,0);
    add(0,0,0, 5,9,0, 1,3,  1,5,3,1,0);
    add(0,0,0, 5,9,0, 1,3,  1,5,3,1,0);
    add(0,0,0, 5,9,0, 1,3,  1,5,3,1,0);
    add(0,1,0, 5,9,0, 1,3,  0,5,3,0,0);
    // f_start > f_stop: one dwell period then done
    add(1,0,0, 9,5,1, 2,1,  1,9,1,1,0);
    add(0,0,0, 9,5,1, 2,1,  1,9,1,1,0);
    add(0,0,0, 9,5,1, 2,1,  0,9,1,1,1);
    add(0,0,0, 9,5,1, 2,1,  0,9,1,0,0);

    foreach (vq[i]) begin
      drive(vq[i].start, vq[i].stop, vq[i].mode, vq[i].fs, vq[i].fe,
            vq[i].fd, vq[i].dw, vq[i].ps);
      @(posedge clk); #1;
      chk_all("vec", i, vq[i].x_en, vq[i].x_incr, vq[i].x_step,
              vq[i].x_busy, vq[i].x_done);
    end

    // rst mid-sweep
    drive(1, 0, 0, 4, 10, 3, 2, 64);
    @(posedge clk); #1;
    drive(0, 0, 0, 4, 10, 3, 2, 64);
    repeat (2) @(posedge clk);
    #1;
    chk_all("pre_rst", 0, 1, 7, 64, 1, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk_all("mid_rst", 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk_all("post_rst", 0, 0, 0, 0, 0, 0);

`ifdef SWEEP_PINGPONG_EN
    begin
      logic [7:0] pp [0:6];
      pp[0] = 2; pp[1] = 4; pp[2] = 6; pp[3] = 4; pp[4] = 2; pp[5] = 4; pp[6] = 6;
      drive(1, 0, 1, 2, 6, 2, 1, 11);
      for (int k = 0; k < 7; k++) begin
        @(posedge clk); #1;
        chk_all("pingpong", k, 1, pp[k], 11, 1, 0);
        start = 1'b0;
      end
      stop = 1'b1;
      @(posedge clk); #1;
      chk_all("pp_stop", 0, 0, 6, 11, 0, 0);
      stop = 1'b0;
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sinegen_sweep_ctrl.md
Name: sinegen_sweep_ctrl

Overview:
Frequency-sweep scheduler that drives the en/incr/step control inputs of the sine generator.
- On a start pulse, steps incr from f_start toward f_stop in increments of f_delta.
- Holds each value for a programmable dwell period.
- Ends in one-shot mode, or repeats in continuous mode.
- Sits between the top-level control inputs and the sine generator. All outputs are registered.

Parameters:
WIDTH, 8, width of incr/step/frequency fields; matches the sine generator WIDTH
DWELL_W, 16, width of the dwell counter and dwell input

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-high reset
start  input  1  1-cycle request to begin a sweep; honoured only in IDLE
stop  input  1  abort request; honoured in any non-IDLE state
mode  input  1  0 = one-shot, 1 = continuous; latched on start
f_start  input  WIDTH  first incr value; latched on start
f_stop  input  WIDTH  upper incr bound, inclusive; latched on start
f_delta  input  WIDTH  incr increment per dwell period; latched on start
dwell  input  DWELL_W  cycles per incr value, 0 treated as 1; latched on start
phase_step  input  WIDTH  phase offset for the second output; latched on start
en  output  1  enable to the sine generator counter
incr  output  WIDTH  phase increment to the sine generator counter
step  output  WIDTH  phase offset to the sine generator ROM
busy  output  1  high in any state other than IDLE
done  output  1  1-cycle pulse on normal sweep completion

Behaviour:
- Reset: state IDLE; en=0, incr=0, step=0, busy=0, done=0; dwell counter=0; direction=up.
- States: IDLE, SWEEP, DONE.
- IDLE:
  - start=1 and stop=0 sampled at edge t: latch all config inputs and enter SWEEP.
  - From t+1: en=1, incr=f_start, step=phase_step, busy=1, dwell counter=max(dwell,1)-1.
  - start and stop both high in IDLE: remain IDLE.
- SWEEP:
  - Each cycle: if the dwell counter is nonzero, decrement it. Otherwise evaluate next=incr+f_delta in WIDTH+1 bits.
  - next<=f_stop: incr<=next[WIDTH-1:0]; reload the dwell counter.
  - next>f_stop (includes carry out) and mode=0: go to DONE; en<=0; incr holds its last value.
  - next>f_stop and mode=1: incr<=f_start; reload the dwell counter (sawtooth).
  - Each incr value is visible for exactly max(dwell,1) cycles.
- f_delta=0: next=incr, which never exceeds f_stop when f_start<=f_stop. incr holds f_start until stop.
- f_start>f_stop: f_start is output for one dwell period, then end-of-sweep handling applies as above.
- DONE: lasts 1 cycle with done=1, en=0, busy=1. Then IDLE with busy=0 and done=0.
- stop=1 in SWEEP or DONE: next cycle state IDLE, en=0, busy=0, done=0 (no done pulse). incr and step hold their values.
- start while busy: ignored. Config input changes mid-sweep: ignored.
- rst mid-sweep: all outputs return to reset values on the next edge.

Optional Feature:
SWEEP_PINGPONG_EN
- Defined: continuous mode (mode=1) reverses direction at the bound instead of reloading.
  - Up phase, next>f_stop: direction<=down; incr<=incr-f_delta. If that result would fall below f_start (borrow-aware), incr<=f_start instead.
  - Down phase: next=incr-f_delta in WIDTH+1 bits. If it is below f_start or borrows, direction<=up and incr<=incr+f_delta, clamped to f_stop. Otherwise incr<=next.
  - One-shot mode is unchanged.
- Not defined: no direction register; mode=1 behaves as a sawtooth.

Test Plan:
- Reset: rst=1 for 2 cycles with random inputs -> en=0, incr=0, step=0, busy=0, done=0.
- One-shot: f_start=4, f_stop=10, f_delta=3, dwell=2, mode=0, phase_step=64, start at cycle 0.
  - Cycles 1-2 incr=4, cycles 3-4 incr=7, cycles 5-6 incr=10, en=1, step=64.
  - Cycle 7: done=1, en=0, incr=10. Cycle 8: busy=0.
- Carry and dwell=0: f_start=250, f_stop=255, f_delta=4, dwell=0, mode=0.
  - incr=250 then 254, one cycle each. 254+4 carries -> DONE on the next cycle.
- Continuous sawtooth: f_start=1, f_stop=3, f_delta=1, dwell=1, mode=1.
  - incr sequence 1,2,3,1,2,3,... Assert stop -> next cycle en=0, busy=0, no done pulse.
- Priority: start+stop together in IDLE -> stays IDLE. start during SWEEP -> no restart and incr sequence unaffected. rst mid-sweep -> reset values next cycle.
- Ping-pong (SWEEP_PINGPONG_EN defined): f_start=2, f_stop=6, f_delta=2, dwell=1, mode=1.
  - incr sequence 2,4,6,4,2,4,6,...
